// File: rtl/studio_pkg.sv
// Studio II memory arbiter: shared defaults, FSM states and grant sources.
package studio_pkg;

  localparam int          STUDIO_ADDR_W    = 12;
  localparam logic [11:0] STUDIO_CART_BASE = 12'h400;
  localparam int          STUDIO_CART_SIZE = 1024;
  localparam int          STUDIO_MAX_WAIT  = 3;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    FLUSH
  } state_e;

  typedef enum logic [1:0] {
    G_NONE,
    G_DL,
    G_DMA,
    G_CPU
  } grant_e;

endpackage

// File: rtl/studio_dl_buffer.sv
// Cartridge loader staging: one-entry pending write, bound check
// and sticky overflow flag.
module studio_dl_buffer
  import studio_pkg::*;
#(
  parameter int                ADDR_W    = STUDIO_ADDR_W,
  parameter logic [ADDR_W-1:0] CART_BASE = ADDR_W'(STUDIO_CART_BASE),
  parameter int                CART_SIZE = STUDIO_CART_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ovf_clr,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [7:0]        pend_data,
  output logic              overflow
);

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              ovf_q, ovf_d;
  logic              accept;
  logic              in_range;

  assign accept   = ioctl_download && ioctl_wr;
  assign in_range = ioctl_addr < 25'(CART_SIZE);

  // The pending entry always drains the cycle after it is loaded,
  // so its valid bit simply follows the accepted strobe.
  always_comb begin
    pend_valid_d = accept && in_range;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (accept && in_range) begin
      pend_addr_d = CART_BASE + ioctl_addr[ADDR_W-1:0];
      pend_data_d = ioctl_dout;
    end
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (accept && !in_range) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;
  assign pend_data  = pend_data_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/studio_mem_arbiter.sv
// Studio II shared RAM/ROM arbiter: cartridge loader, video DMA
// and CPU with fixed priority and a CPU starvation guard.
module studio_mem_arbiter
  import studio_pkg::*;
#(
  parameter int                ADDR_W    = STUDIO_ADDR_W,
  parameter logic [ADDR_W-1:0] CART_BASE = ADDR_W'(STUDIO_CART_BASE),
  parameter int                CART_SIZE = STUDIO_CART_SIZE,
  parameter int                MAX_WAIT  = STUDIO_MAX_WAIT
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              dl_busy,
  output logic              dl_overflow
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  grant_e            grant;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cpu_rv_q, cpu_rv_d;
  logic              dma_rv_q, dma_rv_d;
  logic [7:0]        cpu_rd_q, cpu_rd_d;
  logic [7:0]        dma_rd_q, dma_rd_d;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_data;
  logic              ovf;
  logic              ovf_clr;

  assign ovf_clr = (state_q == RUN) && ioctl_download;

  studio_dl_buffer #(
    .ADDR_W    (ADDR_W),
    .CART_BASE (CART_BASE),
    .CART_SIZE (CART_SIZE)
  ) u_dl_buffer (
    .clk            (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ovf_clr        (ovf_clr),
    .pend_valid     (pend_valid),
    .pend_addr      (pend_addr),
    .pend_data      (pend_data),
    .overflow       (ovf)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (ioctl_download) state_d = LOAD;
      LOAD:    if (!ioctl_download) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Grants are masked during reset so every output reads zero.
  always_comb begin
    grant = G_NONE;
    if (reset) begin
      grant = G_NONE;
    end else if (pend_valid) begin
      grant = G_DL;
    end else if (state_q != RUN) begin
      if (dma_req) grant = G_DMA;
    end else if (cpu_req && dma_req && wait_q == WAIT_MAX) begin
      grant = G_CPU;
    end else if (dma_req) begin
      grant = G_DMA;
    end else if (cpu_req) begin
      grant = G_CPU;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (grant)
      G_DL: begin
        mem_addr  = pend_addr;
        mem_we    = 1'b1;
        mem_wdata = pend_data;
      end
      G_DMA: mem_addr = dma_addr;
      G_CPU: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_we ? cpu_wdata : 8'h00;
      end
      default: ;
    endcase
  end

  assign cpu_ack = (grant == G_CPU);
  assign dma_ack = (grant == G_DMA);

  always_comb begin
    cpu_rv_d = cpu_ack && !cpu_we;
    dma_rv_d = dma_ack;
    cpu_rd_d = cpu_rv_q ? mem_rdata : cpu_rd_q;
    dma_rd_d = dma_rv_q ? mem_rdata : dma_rd_q;
    wait_d   = wait_q;
    if (!cpu_req || cpu_ack) begin
      wait_d = '0;
    end else if (state_q == RUN && wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= RUN;
      wait_q   <= '0;
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cpu_rv_q <= cpu_rv_d;
      dma_rv_q <= dma_rv_d;
      cpu_rd_q <= cpu_rd_d;
      dma_rd_q <= dma_rd_d;
    end
  end

  assign cpu_rvalid  = cpu_rv_q && !reset;
  assign dma_rvalid  = dma_rv_q && !reset;
  assign cpu_rdata   = reset ? 8'h00 : (cpu_rv_q ? mem_rdata : cpu_rd_q);
  assign dma_rdata   = reset ? 8'h00 : (dma_rv_q ? mem_rdata : dma_rd_q);
  assign dl_busy     = (state_q != RUN) && !reset;
  assign dl_overflow = ovf && !reset;

endmodule
